// File: rtl/fetch_debug_controller.sv
// Host-side debug controller: loads instruction memory from a byte stream,
// reads words back, and runs or single-steps the CPU pipeline.
module fetch_debug_controller #(
  parameter int NB_INSTR = 32,
  parameter int N_ADDR   = 2048
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic [15:0]         o_instrmem_addr,
  output logic [NB_INSTR-1:0] o_instrmem_data,
  output logic [3:0]          o_instrmem_we,
  output logic                o_instrmem_re,
  input  logic [NB_INSTR-1:0] i_instrmem_data,
  output logic                o_valid,
  input  logic                i_halt,
  output logic                o_busy,
  output logic [3:0]          dbg_state
);

  localparam int AW = (N_ADDR > 1) ? $clog2(N_ADDR) : 1;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LD_CNT_H  = 4'd1;
  localparam logic [3:0] S_LD_CNT_L  = 4'd2;
  localparam logic [3:0] S_LD_BYTE   = 4'd3;
  localparam logic [3:0] S_LD_WRITE  = 4'd4;
  localparam logic [3:0] S_RUN       = 4'd5;
  localparam logic [3:0] S_STEP      = 4'd6;
  localparam logic [3:0] S_RD_ADDR_H = 4'd7;
  localparam logic [3:0] S_RD_ADDR_L = 4'd8;
  localparam logic [3:0] S_RD_REQ    = 4'd9;
  localparam logic [3:0] S_RD_WAIT   = 4'd10;
  localparam logic [3:0] S_RD_SEND   = 4'd11;
  localparam logic [3:0] S_ACK       = 4'd12;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_READ = 8'h04;
  localparam logic [7:0] CMD_STOP = 8'h05;
  localparam logic [7:0] ACK_BYTE = 8'hAA;

  // Handshake: a tx byte transfers on a rising edge where o_tx_valid and
  // i_tx_ready are both high; o_tx_data is frozen while valid and not ready.

  logic [3:0]    state;
  logic [7:0]    hi_byte;
  logic [15:0]   words_left;
  logic [AW-1:0] index;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_buf;
  logic [31:0]   rd_buf;
  logic [15:0]   rd_addr_full;

  assign rd_addr_full = {hi_byte, i_rx_data};

  assign o_valid       = ((state == S_RUN) && !i_halt) || (state == S_STEP);
  assign o_instrmem_we = (state == S_LD_WRITE) ? 4'hF : 4'h0;
  assign o_instrmem_re = (state == S_RD_REQ);
  assign o_busy        = (state != S_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= S_IDLE;
      hi_byte         <= 8'h00;
      words_left      <= 16'h0000;
      index           <= '0;
      byte_cnt        <= 2'd0;
      word_buf        <= 24'h000000;
      rd_buf          <= 32'h0000_0000;
      o_tx_data       <= 8'h00;
      o_tx_valid      <= 1'b0;
      o_instrmem_addr <= 16'h0000;
      o_instrmem_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: state <= S_LD_CNT_H;
              CMD_RUN:  state <= S_RUN;
              CMD_STEP: state <= S_STEP;
              CMD_READ: state <= S_RD_ADDR_H;
              default:  state <= S_IDLE;
            endcase
          end
        end

        S_LD_CNT_H: begin
          if (i_rx_valid) begin
            hi_byte <= i_rx_data;
            state   <= S_LD_CNT_L;
          end
        end

        S_LD_CNT_L: begin
          if (i_rx_valid) begin
            words_left <= rd_addr_full;
            index      <= '0;
            byte_cnt   <= 2'd0;
            state      <= (rd_addr_full == 16'h0000) ? S_IDLE : S_LD_BYTE;
          end
        end

        S_LD_BYTE: begin
          if (i_rx_valid) begin
            if (byte_cnt == 2'd3) begin
              o_instrmem_data <= NB_INSTR'({word_buf, i_rx_data});
              o_instrmem_addr <= 16'(index);
              byte_cnt        <= 2'd0;
              state           <= S_LD_WRITE;
            end else begin
              word_buf <= {word_buf[15:0], i_rx_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end

        S_LD_WRITE: begin
          index      <= (index == AW'(N_ADDR - 1)) ? '0 : index + 1'b1;
          words_left <= words_left - 16'd1;
          if (words_left == 16'd1) begin
            byte_cnt   <= 2'd0;
            o_tx_data  <= ACK_BYTE;
            o_tx_valid <= 1'b1;
            state      <= S_ACK;
          end else begin
            // A byte landing during the write slot opens the next word.
            if (i_rx_valid) begin
              word_buf <= {word_buf[15:0], i_rx_data};
              byte_cnt <= 2'd1;
            end else begin
              byte_cnt <= 2'd0;
            end
            state <= S_LD_BYTE;
          end
        end

        S_RUN: begin
          if (i_halt) begin
            o_tx_data  <= ACK_BYTE;
            o_tx_valid <= 1'b1;
            state      <= S_ACK;
          end else if (i_rx_valid && (i_rx_data == CMD_STOP)) begin
            state <= S_IDLE;
          end
        end

        S_STEP: begin
          o_tx_data  <= ACK_BYTE;
          o_tx_valid <= 1'b1;
          state      <= S_ACK;
        end

        S_RD_ADDR_H: begin
          if (i_rx_valid) begin
            hi_byte <= i_rx_data;
            state   <= S_RD_ADDR_L;
          end
        end

        S_RD_ADDR_L: begin
          if (i_rx_valid) begin
            o_instrmem_addr <= 16'(32'(rd_addr_full) % N_ADDR);
            state           <= S_RD_REQ;
          end
        end

        S_RD_REQ: begin
          state <= S_RD_WAIT;
        end

        S_RD_WAIT: begin
          rd_buf     <= 32'(i_instrmem_data);
          o_tx_data  <= i_instrmem_data[NB_INSTR-1 -: 8];
          o_tx_valid <= 1'b1;
          byte_cnt   <= 2'd0;
          state      <= S_RD_SEND;
        end

        S_RD_SEND: begin
          if (i_tx_ready) begin
            if (byte_cnt == 2'd3) begin
              o_tx_valid <= 1'b0;
              byte_cnt   <= 2'd0;
              state      <= S_IDLE;
            end else begin
              // rd_buf[31:24] is the byte currently on the wire.
              o_tx_data <= rd_buf[23:16];
              rd_buf    <= {rd_buf[23:0], 8'h00};
              byte_cnt  <= byte_cnt + 2'd1;
            end
          end
        end

        S_ACK: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
